// File: rtl/pix_pkg.sv
// Shared defaults and helpers for the pixel window buffer.
package pix_pkg;

  localparam int PIX_W_DEF     = 8;
  localparam int IN_PIX_DEF    = 70;
  localparam int K_DEF         = 3;
  localparam int ROW_BEATS_DEF = 10;
  localparam int ROWS_DEF      = 482;

  // Ceiling log2, never narrower than one bit so counters stay declarable.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((32'sd1 << r) < n) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pix_line_mem.sv
// Single-port line buffer; a write and a read to the same entry return the old contents.
module pix_line_mem
  import pix_pkg::*;
#(
  parameter int DEPTH = ROW_BEATS_DEF,
  parameter int AW    = clog2(DEPTH),
  parameter int DW    = IN_PIX_DEF * PIX_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  // Storage array carries no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Read register holds its value between reads so a stalled window stays put.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/pix_window_buf.sv
// Vertical K-row window generator: each accepted row segment is emitted together
// with the segments at the same column of the K-1 preceding rows.
module pix_window_buf
  import pix_pkg::*;
#(
  parameter int PIX_W     = PIX_W_DEF,
  parameter int IN_PIX    = IN_PIX_DEF,
  parameter int K         = K_DEF,
  parameter int ROW_BEATS = ROW_BEATS_DEF,
  parameter int ROWS      = ROWS_DEF,
  localparam int COL_W    = clog2(ROW_BEATS),
  localparam int ROW_W    = clog2(ROWS),
  localparam int SEG_W    = IN_PIX * PIX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SEG_W-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [K*SEG_W-1:0]   out_data,
  output logic [COL_W-1:0]     out_col,
  output logic [ROW_W-1:0]     out_row,
  output logic                 frame_done
);

  localparam int NBUF  = K - 1;
  localparam int PTR_W = clog2(NBUF);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(ROW_BEATS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0] ROW_PRIME = ROW_W'(K - 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NBUF - 1);

  logic [COL_W-1:0]   r_col;
  logic [ROW_W-1:0]   r_row;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_out_ptr;
  logic               r_out_valid;
  logic [COL_W-1:0]   r_out_col;
  logic [ROW_W-1:0]   r_out_row;
  logic [SEG_W-1:0]   r_cur;
  logic               w_accept;
  logic               w_emit;
  logic               w_col_wrap;
  logic               w_row_wrap;
  logic [PTR_W-1:0]   w_idx;
  logic [SEG_W-1:0]   w_rd [NBUF];
  logic [K*SEG_W-1:0] w_out_data;

  assign in_ready   = !r_out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_emit     = w_accept && (r_row >= ROW_PRIME);
  assign w_col_wrap = (r_col == COL_LAST);
  assign w_row_wrap = (r_row == ROW_LAST);

  // Position counters; r_ptr names the buffer holding the oldest row, which the current row overwrites.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
      r_ptr <= '0;
    end else if (w_accept) begin
      if (w_col_wrap) begin
        r_col <= '0;
        if (w_row_wrap) begin
          r_row <= '0;
          r_ptr <= '0;
        end else begin
          r_row <= r_row + ROW_W'(1);
          r_ptr <= (r_ptr == PTR_LAST) ? '0 : r_ptr + PTR_W'(1);
        end
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // Output beat registers, loaded only by window-producing beats and held under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_col   <= '0;
      r_out_row   <= '0;
      r_out_ptr   <= '0;
      r_cur       <= '0;
    end else if (w_emit) begin
      r_out_valid <= 1'b1;
      r_out_col   <= r_col;
      r_out_row   <= r_row;
      r_out_ptr   <= r_ptr;
      r_cur       <= in_data;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  for (genvar g = 0; g < NBUF; g++) begin : g_line
    pix_line_mem #(
      .DEPTH (ROW_BEATS),
      .AW    (COL_W),
      .DW    (SEG_W)
    ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_accept && (r_ptr == PTR_W'(g))),
      .i_re    (w_emit),
      .i_addr  (r_col),
      .i_wdata (in_data),
      .o_rdata (w_rd[g])
    );
  end

  // Stack the buffered rows oldest-first above the current segment.
  always_comb begin
    w_out_data = '0;
    w_idx      = '0;
    for (int j = 0; j < NBUF; j++) begin
      w_idx = PTR_W'((int'(r_out_ptr) + j) % NBUF);
      w_out_data[(K-1-j)*SEG_W +: SEG_W] = w_rd[w_idx];
    end
    w_out_data[SEG_W-1:0] = r_cur;
  end

  assign out_valid  = r_out_valid;
  assign out_data   = w_out_data;
  assign out_col    = r_out_col;
  assign out_row    = r_out_row;
  assign frame_done = r_out_valid && (r_out_row == ROW_LAST) && (r_out_col == COL_LAST);

endmodule

// File: tb/tb_pix_window_buf.sv
// Scoreboard bench for pix_window_buf on a small 4-row, 2-beat frame.
module tb_pix_window_buf;

  localparam int PIX_W     = 8;
  localparam int IN_PIX    = 4;
  localparam int K         = 3;
  localparam int ROW_BEATS = 2;
  localparam int ROWS      = 4;
  localparam int SEG       = IN_PIX * PIX_W;
  localparam int OW        = K * SEG;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [SEG-1:0] in_data = '0;
  logic           in_ready;
  logic           out_valid;
  logic [OW-1:0]  out_data;
  logic [0:0]     out_col;
  logic [1:0]     out_row;
  logic           frame_done;

  pix_window_buf #(
    .PIX_W(PIX_W), .IN_PIX(IN_PIX), .K(K), .ROW_BEATS(ROW_BEATS), .ROWS(ROWS)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_col(out_col), .out_row(out_row), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] data;
    int            col;
    int            row;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_row = 0;
  int   m_col = 0;
  bit   m_ov = 1'b0;
  int   n_acc = 0;
  int   n_out = 0;
  int   n_fd = 0;
  exp_t e;
  bit   exp_fd;

  function automatic logic [SEG-1:0] beat(input int r, input int c);
    logic [7:0] b;
    b = 8'(r * 16 + c);
    return {IN_PIX{b}};
  endfunction

  task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model and scoreboard, evaluated away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      m_row = 0;
      m_col = 0;
      m_ov  = 1'b0;
    end else begin
      check("out_valid", out_valid, m_ov);
      check("in_ready", in_ready, !m_ov || out_ready);
      exp_fd = m_ov && (sb.size() > 0) && (sb[0].row == ROWS - 1) && (sb[0].col == ROW_BEATS - 1);
      check("frame_done", frame_done, exp_fd);
      if (m_ov && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          check("out_data", out_data, e.data);
          check("out_col", out_col, e.col);
          check("out_row", out_row, e.row);
          n_out++;
          if (frame_done) n_fd++;
        end
        m_ov = 1'b0;
      end
      if (in_valid && in_ready) begin
        n_acc++;
        if (m_row >= K - 1) begin
          e.data = {beat(m_row - 2, m_col), beat(m_row - 1, m_col), beat(m_row, m_col)};
          e.col  = m_col;
          e.row  = m_row;
          sb.push_back(e);
          m_ov = 1'b1;
        end
        if (m_col == ROW_BEATS - 1) begin
          m_col = 0;
          m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
        end else begin
          m_col = m_col + 1;
        end
      end
    end
  end

  // Called and returns one time unit after a rising edge.
  task automatic run(input int n_beats, input int pv, input int pr, input int budget);
    int target;
    int cyc;
    target = n_acc + n_beats;
    cyc = 0;
    while (n_acc < target && cyc < budget) begin
      in_valid  = ($urandom_range(99) < pv);
      out_ready = ($urandom_range(99) < pr);
      in_data   = beat(m_row, m_col);
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    if (n_acc < target) check("run_timeout", 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int out0;
  int fd0;

  initial begin
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_col", out_col, 1'b0);
    check("rst_out_row", out_row, 2'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // One frame at full throughput: rows 2 and 3 give four windows.
    out0 = n_out; fd0 = n_fd;
    run(8, 100, 100, 40);
    idle(3);
    check("frame1_outputs", n_out - out0, 4);
    check("frame1_done", n_fd - fd0, 1);

    // Backpressure on the first window of a frame.
    out0 = n_out;
    run(5, 100, 100, 40);
    in_valid  = 1'b1;
    in_data   = beat(m_row, m_col);
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_data", out_data, {beat(0, 0), beat(1, 0), beat(2, 0)});
      check("stall_in_ready", in_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    run(3, 100, 100, 40);
    idle(3);
    check("stall_outputs", n_out - out0, 4);

    // Two back-to-back frames.
    out0 = n_out; fd0 = n_fd;
    run(16, 100, 100, 80);
    idle(3);
    check("two_frames_outputs", n_out - out0, 8);
    check("two_frames_done", n_fd - fd0, 2);

    // Reset mid-frame with a held window, then a fresh frame.
    run(5, 100, 100, 40);
    out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", out_valid, 1'b0);
    check("post_rst_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    out0 = n_out; fd0 = n_fd;
    run(8, 100, 100, 40);
    idle(3);
    check("after_rst_outputs", n_out - out0, 4);
    check("after_rst_done", n_fd - fd0, 1);

    // Three frames with random valid/ready.
    out0 = n_out; fd0 = n_fd;
    run(24, 50, 50, 1000);
    idle(6);
    check("random_outputs", n_out - out0, 12);
    check("random_done", n_fd - fd0, 3);
    check("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
